// File: rtl/axis_video_pkg.sv
// Shared types for the 24-bit AXI4-Stream video path: pixel and beat structs,
// upsampler FSM states and the per-component rounding average.
package axis_video_pkg;

    localparam int COMP_W = 8;
    localparam int DATA_W = 3 * COMP_W;

    typedef struct packed {
        logic [COMP_W-1:0] c2;
        logic [COMP_W-1:0] c1;
        logic [COMP_W-1:0] c0;
    } pix_t;

    typedef struct packed {
        pix_t pix;
        logic user;
        logic last;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_NEXT,
        ST_EMIT_A,
        ST_EMIT_B
    } hups_state_t;

    function automatic logic [COMP_W-1:0] comp_avg(input logic [COMP_W-1:0] a,
                                                   input logic [COMP_W-1:0] b);
        logic [COMP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{COMP_W{1'b0}}, 1'b1};
        return sum[COMP_W:1];
    endfunction

    function automatic pix_t pix_avg(input pix_t a, input pix_t b);
        pix_t r;
        r.c2 = comp_avg(a.c2, b.c2);
        r.c1 = comp_avg(a.c1, b.c1);
        r.c0 = comp_avg(a.c0, b.c0);
        return r;
    endfunction

endpackage

// File: rtl/axis_video_obuf.sv
// Registered AXI4-Stream output stage: load captures a beat, accept reports the handshake.
// Latency: one cycle from load to m_tvalid.
// Backpressure: beat is held stable while m_tready is low; caller loads only when empty or accepting.
module axis_video_obuf
    import axis_video_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              user,
    input  logic              last,
    output logic              accept,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic              m_tlast
);

    assign accept = m_tvalid & m_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tuser  <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tdata  <= data;
            m_tvalid <= 1'b1;
            m_tuser  <= user;
            m_tlast  <= last;
        end else if (accept) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_hups_1to2.sv
// Horizontal 1:2 upsampler: every input pixel becomes two output beats (replica or rounded average).
// Latency: first beat one cycle after the input handshake (MODE=1: after the lookahead pixel or tlast).
// Backpressure: input is refused while either output beat of the held pixel is pending.
module axis_hups_1to2 #(
    parameter int MODE   = 1,
    parameter int COMP_W = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [3*COMP_W-1:0] s_axis_video_tdata,
    input  logic                s_axis_video_tvalid,
    output logic                s_axis_video_tready,
    input  logic                s_axis_video_tuser,
    input  logic                s_axis_video_tlast,
    output logic [3*COMP_W-1:0] m_axis_video_tdata,
    output logic                m_axis_video_tvalid,
    input  logic                m_axis_video_tready,
    output logic                m_axis_video_tuser,
    output logic                m_axis_video_tlast,
    output logic                sof_early
);
    import axis_video_pkg::*;

    hups_state_t state, state_nxt;
    beat_t       h_q, n_q, s_beat, o_beat;
    pix_t        odd_pix;
    logic        rdy_en_q, prev_last_q, sof_q;
    logic        s_hs, o_acc, o_load;
    logic        h_ld_in, h_ld_n, n_ld, use_avg;

    assign s_beat = {s_axis_video_tdata, s_axis_video_tuser, s_axis_video_tlast};

    assign s_axis_video_tready = rdy_en_q & ((state == ST_IDLE) | (state == ST_WAIT_NEXT));
    assign s_hs                = s_axis_video_tready & s_axis_video_tvalid;
    assign sof_early           = sof_q;

    // A lookahead pixel that opens a new frame must not bleed into the old line.
    assign use_avg = (MODE != 0) && !h_q.last && !n_q.user;
    assign odd_pix = use_avg ? pix_avg(h_q.pix, n_q.pix) : h_q.pix;

    always_comb begin
        state_nxt = state;
        o_load    = 1'b0;
        o_beat    = '0;
        h_ld_in   = 1'b0;
        h_ld_n    = 1'b0;
        n_ld      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_hs) begin
                    h_ld_in = 1'b1;
                    if ((MODE == 0) || s_beat.last) begin
                        o_load    = 1'b1;
                        o_beat    = '{pix: s_beat.pix, user: s_beat.user, last: 1'b0};
                        state_nxt = ST_EMIT_A;
                    end else begin
                        state_nxt = ST_WAIT_NEXT;
                    end
                end
            end
            ST_WAIT_NEXT: begin
                if (s_hs) begin
                    n_ld      = 1'b1;
                    o_load    = 1'b1;
                    o_beat    = '{pix: h_q.pix, user: h_q.user, last: 1'b0};
                    state_nxt = ST_EMIT_A;
                end
            end
            ST_EMIT_A: begin
                if (o_acc) begin
                    o_load    = 1'b1;
                    o_beat    = '{pix: odd_pix, user: 1'b0, last: h_q.last};
                    state_nxt = ST_EMIT_B;
                end
            end
            ST_EMIT_B: begin
                if (o_acc) begin
                    if ((MODE == 0) || h_q.last) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        h_ld_n = 1'b1;
                        if (n_q.last) begin
                            o_load    = 1'b1;
                            o_beat    = '{pix: n_q.pix, user: n_q.user, last: 1'b0};
                            state_nxt = ST_EMIT_A;
                        end else begin
                            state_nxt = ST_WAIT_NEXT;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            h_q         <= '0;
            n_q         <= '0;
            rdy_en_q    <= 1'b0;
            prev_last_q <= 1'b1;
            sof_q       <= 1'b0;
        end else begin
            state    <= state_nxt;
            rdy_en_q <= 1'b1;
            // Start of frame while the previous accepted beat left its line open.
            sof_q    <= s_hs & s_beat.user & ~prev_last_q;
            if (s_hs) begin
                prev_last_q <= s_beat.last;
            end
            if (h_ld_in) begin
                h_q <= s_beat;
            end else if (h_ld_n) begin
                h_q <= n_q;
            end
            if (n_ld) begin
                n_q <= s_beat;
            end
        end
    end

    axis_video_obuf u_obuf (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (o_load),
        .data     (o_beat.pix),
        .user     (o_beat.user),
        .last     (o_beat.last),
        .accept   (o_acc),
        .m_tdata  (m_axis_video_tdata),
        .m_tvalid (m_axis_video_tvalid),
        .m_tready (m_axis_video_tready),
        .m_tuser  (m_axis_video_tuser),
        .m_tlast  (m_axis_video_tlast)
    );

endmodule

// File: tb/tb_axis_hups_1to2.sv
// Drives a replicate (MODE=0) and an interpolate (MODE=1) instance with the same
// pixel streams and checks both against a line-level reference model.
module tb_axis_hups_1to2;

    localparam int LINE_PIX = 32;
    localparam int LINES    = 12;
    localparam int RAMP0 [8] = '{10, 10, 20, 20, 30, 30, 40, 40};
    localparam int RAMP1 [8] = '{10, 15, 20, 25, 30, 35, 40, 40};

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [23:0] s_dat [2];
    logic        s_vld [2];
    logic        s_usr [2];
    logic        s_lst [2];
    logic        s_rdy [2];
    logic [23:0] m_dat [2];
    logic        m_vld [2];
    logic        m_usr [2];
    logic        m_lst [2];
    logic        m_rdy [2];
    logic        sof   [2];

    axis_hups_1to2 #(.MODE(0), .COMP_W(8)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_video_tdata(s_dat[0]), .s_axis_video_tvalid(s_vld[0]),
        .s_axis_video_tready(s_rdy[0]), .s_axis_video_tuser(s_usr[0]),
        .s_axis_video_tlast(s_lst[0]),
        .m_axis_video_tdata(m_dat[0]), .m_axis_video_tvalid(m_vld[0]),
        .m_axis_video_tready(m_rdy[0]), .m_axis_video_tuser(m_usr[0]),
        .m_axis_video_tlast(m_lst[0]), .sof_early(sof[0])
    );

    axis_hups_1to2 #(.MODE(1), .COMP_W(8)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_video_tdata(s_dat[1]), .s_axis_video_tvalid(s_vld[1]),
        .s_axis_video_tready(s_rdy[1]), .s_axis_video_tuser(s_usr[1]),
        .s_axis_video_tlast(s_lst[1]),
        .m_axis_video_tdata(m_dat[1]), .m_axis_video_tvalid(m_vld[1]),
        .m_axis_video_tready(m_rdy[1]), .m_axis_video_tuser(m_usr[1]),
        .m_axis_video_tlast(m_lst[1]), .sof_early(sof[1])
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [25:0] in_q [$];
    logic [25:0] exp0 [$];
    logic [25:0] exp1 [$];
    logic [25:0] cap0 [$];
    logic [25:0] cap1 [$];
    logic [25:0] refc0 [$];
    logic [25:0] refc1 [$];
    int          sof_cnt [2];
    int          sof_exp;
    logic        model_prev_last = 1'b1;
    int          bp_mode = 2;
    bit          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] gray(input int v);
        return {3{8'(v)}};
    endfunction

    function automatic logic [23:0] ref_avg(input logic [23:0] a, input logic [23:0] b);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) begin
            int x, y;
            x = int'(a[8*c +: 8]);
            y = int'(b[8*c +: 8]);
            r[8*c +: 8] = 8'((x + y + 1) / 2);
        end
        return r;
    endfunction

    task automatic add_pix(input logic [23:0] p, input logic u, input logic l);
        in_q.push_back({p, u, l});
    endtask

    // Each input pixel yields {pixel, user} then {odd pixel, tlast}; the odd pixel
    // averages with the next pixel of the same line unless replication applies.
    task automatic build_exp();
        sof_exp = 0;
        for (int i = 0; i < in_q.size(); i++) begin
            logic [23:0] p, odd;
            logic        u, l;
            p = in_q[i][25:2];
            u = in_q[i][1];
            l = in_q[i][0];
            if (u && !model_prev_last) sof_exp++;
            model_prev_last = l;
            exp0.push_back({p, u, 1'b0});
            exp0.push_back({p, 1'b0, l});
            odd = p;
            if (!l && (i + 1 < in_q.size()) && !in_q[i+1][1])
                odd = ref_avg(p, in_q[i+1][25:2]);
            exp1.push_back({p, u, 1'b0});
            exp1.push_back({odd, 1'b0, l});
        end
    endtask

    task automatic drive(input int k);
        for (int i = 0; i < in_q.size(); i++) begin
            int gap, budget;
            gap = $urandom_range(0, 2);
            s_vld[k] = 1'b0;
            repeat (gap) @(negedge aclk);
            {s_dat[k], s_usr[k], s_lst[k]} = in_q[i];
            s_vld[k] = 1'b1;
            budget = 2000;
            while (!s_rdy[k] && budget > 0) begin
                @(negedge aclk);
                budget--;
            end
            if (budget == 0) begin
                chk($sformatf("in_timeout%0d", k), 0, 1);
                s_vld[k] = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        s_vld[k] = 1'b0;
        s_usr[k] = 1'b0;
        s_lst[k] = 1'b0;
    endtask

    task automatic run_phase(input string name, input int bp);
        int t;
        exp0.delete(); exp1.delete(); cap0.delete(); cap1.delete();
        sof_cnt[0] = 0;
        sof_cnt[1] = 0;
        build_exp();
        bp_mode = bp;
        mon_en  = 1'b1;
        @(negedge aclk);
        fork
            drive(0);
            drive(1);
        join
        t = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && t < 20000) begin
            @(negedge aclk);
            t++;
        end
        chk({name, "_left0"}, exp0.size(), 0);
        chk({name, "_left1"}, exp1.size(), 0);
        repeat (8) @(negedge aclk);
        chk({name, "_sof0"}, sof_cnt[0], sof_exp);
        chk({name, "_sof1"}, sof_cnt[1], sof_exp);
    endtask

    // Output monitor: chooses m_tready for the coming edge, then scores the beat
    // that edge will accept and checks that stalled beats stay put.
    initial begin : mon
        logic [25:0] held  [2];
        bit          stall [2];
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        forever begin
            @(negedge aclk);
            if (bp_mode != 2) begin
                for (int k = 0; k < 2; k++)
                    m_rdy[k] = (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            end
            for (int k = 0; k < 2; k++) begin
                logic [25:0] b;
                b = {m_dat[k], m_usr[k], m_lst[k]};
                if (!aresetn || !mon_en) begin
                    stall[k] = 1'b0;
                end else begin
                    if (stall[k])
                        chk($sformatf("hold%0d", k), 32'({m_vld[k], b}), 32'({1'b1, held[k]}));
                    if (m_vld[k] && m_rdy[k]) begin
                        if (k == 0) begin
                            if (exp0.size() == 0) chk("extra0", 1, 0);
                            else chk("beat0", 32'(b), 32'(exp0.pop_front()));
                            cap0.push_back(b);
                        end else begin
                            if (exp1.size() == 0) chk("extra1", 1, 0);
                            else chk("beat1", 32'(b), 32'(exp1.pop_front()));
                            cap1.push_back(b);
                        end
                    end
                    stall[k] = m_vld[k] && !m_rdy[k];
                    held[k]  = b;
                    if (sof[k]) sof_cnt[k]++;
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge aclk);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1);
    end

    initial begin : main
        for (int k = 0; k < 2; k++) begin
            s_dat[k] = '0; s_vld[k] = 1'b0; s_usr[k] = 1'b0; s_lst[k] = 1'b0;
            m_rdy[k] = 1'b0;
        end
        repeat (3) @(negedge aclk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("rst_out%0d", k),
                32'({s_rdy[k], m_vld[k], m_dat[k], m_usr[k], m_lst[k], sof[k]}), 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rdy_after_rst0", 32'(s_rdy[0]), 1);
        chk("rdy_after_rst1", 32'(s_rdy[1]), 1);

        in_q.delete();
        add_pix(gray(10), 1'b1, 1'b0);
        add_pix(gray(20), 1'b0, 1'b0);
        add_pix(gray(30), 1'b0, 1'b0);
        add_pix(gray(40), 1'b0, 1'b1);
        run_phase("ramp", 0);
        chk("ramp_cnt0", cap0.size(), 8);
        chk("ramp_cnt1", cap1.size(), 8);
        for (int j = 0; j < 8 && j < cap0.size() && j < cap1.size(); j++) begin
            chk($sformatf("ramp0_%0d", j), 32'(cap0[j][25:2]), 32'(gray(RAMP0[j])));
            chk($sformatf("ramp1_%0d", j), 32'(cap1[j][25:2]), 32'(gray(RAMP1[j])));
            chk($sformatf("ramp_last%0d", j), 32'({cap0[j][0], cap1[j][0]}), (j == 7) ? 3 : 0);
        end

        in_q.delete();
        add_pix(gray(11), 1'b1, 1'b0);
        add_pix(gray(20), 1'b0, 1'b1);
        run_phase("round", 1);
        if (cap1.size() >= 2) chk("round_up", 32'(cap1[1][25:2]), 32'(gray(16)));
        else chk("round_cnt", cap1.size(), 4);

        in_q.delete();
        add_pix(24'h123456, 1'b1, 1'b1);
        run_phase("onepix", 1);
        chk("onepix_cnt0", cap0.size(), 2);
        chk("onepix_cnt1", cap1.size(), 2);

        in_q.delete();
        add_pix(24'h102030, 1'b1, 1'b0);
        add_pix(24'h405060, 1'b0, 1'b0);
        add_pix(24'h708090, 1'b0, 1'b0);
        add_pix(24'hA0B0C0, 1'b1, 1'b0);
        add_pix(24'hD0E0F0, 1'b0, 1'b0);
        add_pix(24'h0F1F2F, 1'b0, 1'b1);
        run_phase("midsof", 1);
        chk("midsof_pulse0", sof_cnt[0], 1);
        chk("midsof_pulse1", sof_cnt[1], 1);
        chk("midsof_cnt1", cap1.size(), 12);

        in_q.delete();
        for (int y = 0; y < LINES; y++)
            for (int x = 0; x < LINE_PIX; x++)
                add_pix(24'($urandom), (x == 0 && y == 0), (x == LINE_PIX - 1));
        run_phase("frame_nobp", 0);
        refc0 = cap0;
        refc1 = cap1;
        run_phase("frame_bp", 1);
        chk("bp_len0", cap0.size(), refc0.size());
        chk("bp_len1", cap1.size(), refc1.size());
        for (int j = 0; j < cap0.size() && j < refc0.size(); j++)
            if (cap0[j] !== refc0[j]) chk($sformatf("bp_same0_%0d", j), 32'(cap0[j]), 32'(refc0[j]));
        for (int j = 0; j < cap1.size() && j < refc1.size(); j++)
            if (cap1[j] !== refc1[j]) chk($sformatf("bp_same1_%0d", j), 32'(cap1[j]), 32'(refc1[j]));

        mon_en  = 1'b0;
        bp_mode = 2;
        @(negedge aclk);
        for (int k = 0; k < 2; k++) begin
            m_rdy[k] = 1'b1;
            {s_dat[k], s_usr[k], s_lst[k]} = {24'h5A5A5A, 1'b1, 1'b1};
            s_vld[k] = 1'b1;
        end
        @(negedge aclk);
        for (int k = 0; k < 2; k++) s_vld[k] = 1'b0;
        @(negedge aclk);
        for (int k = 0; k < 2; k++) m_rdy[k] = 1'b0;
        for (int k = 0; k < 2; k++)
            chk($sformatf("emitb_beat%0d", k), 32'({m_vld[k], m_lst[k], m_dat[k]}), 32'({2'b11, 24'h5A5A5A}));
        #2 aresetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("arst_out%0d", k),
                32'({s_rdy[k], m_vld[k], m_dat[k], m_usr[k], m_lst[k], sof[k]}), 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        model_prev_last = 1'b1;
        @(negedge aclk);
        chk("rdy_after_arst0", 32'(s_rdy[0]), 1);
        chk("rdy_after_arst1", 32'(s_rdy[1]), 1);

        in_q.delete();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 6; x++)
                add_pix(24'($urandom), (x == 0 && y == 0), (x == 5));
        run_phase("fresh", 1);
        chk("fresh_cnt0", cap0.size(), 36);
        chk("fresh_cnt1", cap1.size(), 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_hups_1to2.md
# axis_hups_1to2

Horizontal 1:2 video upsampler on a 24-bit AXI4-Stream video bus (three 8-bit components per beat). It sits directly downstream of the horizontal 2:1 vsampler and consumes its half-width output, so a 240-pixel line is restored to 480 pixels. Each output line carries twice as many beats as its input line. Odd output pixels are either replicas of their source pixel or rounded averages of neighbouring pixels, selected by a parameter. Frame and line markers (tuser, tlast) are preserved.

## Interface
- MODE, 1 — 0: replicate each pixel; 1: interpolate between horizontal neighbours.
- COMP_W, 8 — width of one component; the data bus is 3*COMP_W.
- aclk  in  1  single clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_video_tdata  in  3*COMP_W  input pixel.
- s_axis_video_tvalid  in  1  input valid.
- s_axis_video_tready  out  1  input ready.
- s_axis_video_tuser  in  1  start of frame (first pixel of the frame).
- s_axis_video_tlast  in  1  end of line.
- m_axis_video_tdata  out  3*COMP_W  output pixel.
- m_axis_video_tvalid  out  1  output valid.
- m_axis_video_tready  in  1  output ready.
- m_axis_video_tuser  out  1  start of frame.
- m_axis_video_tlast  out  1  end of line.
- sof_early  out  1  one-cycle pulse when tuser arrives while a line is still open.

## Operation
- Registers:
  - H holds the current pixel with its user and last flags.
  - N holds the lookahead pixel with its user and last flags.
- FSM states are IDLE, WAIT_NEXT, EMIT_A and EMIT_B.
- IDLE: s_tready=1. On an input handshake, H<=input. If MODE=0 or input tlast=1, go to EMIT_A; otherwise go to WAIT_NEXT.
- WAIT_NEXT (MODE=1 only): s_tready=1. On an input handshake, N<=input and go to EMIT_A.
- EMIT_A drives m_tdata=H, m_tuser=H.user, m_tlast=0. On an output handshake, go to EMIT_B.
- EMIT_B drives m_tuser=0 and m_tlast=H.last.
  - m_tdata=H if MODE=0, H.last=1, or N.user=1.
  - Otherwise m_tdata=avg(H,N).
- Leaving EMIT_B on an output handshake:
  - If MODE=0 or H.last=1, go to IDLE.
  - Otherwise set H<=N. Go to EMIT_A if N.last=1; otherwise go to WAIT_NEXT.
- Average rule: avg is computed per component as (a+b+1)>>1 with a COMP_W+1-bit intermediate. No saturation is needed.
- Early start of frame:
  - Trigger: N.user=1 arrives while H is pending without last (MODE=1).
  - sof_early pulses one cycle after the N handshake.
  - H is emitted replicated, and the line is left without tlast.
  - N then starts the new frame with tuser on its EMIT_A beat.
- In MODE=0, an input tuser mid-line is simply forwarded. sof_early pulses only if the previous accepted beat lacked tlast.
- A one-pixel line (tuser=1 and tlast=1 on the same beat) produces 2 beats: the first with tuser=1, the second with tlast=1.
- s_tready=0 in EMIT_A and EMIT_B. Input is never accepted in the same cycle as an output handshake.

## Timing
- Reset values: s_tready=0, m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, sof_early=0, state=IDLE.
- s_tready goes to 1 in the first cycle after reset is released.
- All m_axis_video_* signals come from flops, with no combinational path from s_* or m_tready.
- Once m_tvalid=1, the output holds tdata, tuser and tlast stable until m_tready=1 (AXI4-Stream rule).
- Latency, MODE=0: the first output beat is valid 1 cycle after the input handshake.
- Latency, MODE=1: the first output beat is valid 1 cycle after the second pixel's handshake, or after the tlast pixel's handshake.
- Throughput: at most 2 output beats per 3 cycles per input. The input duty cycle is therefore at most 1/3 with m_tready held at 1.
- Reset asserted mid-line: everything returns to reset values immediately. Held pixels are discarded, with no partial line replay.

## Structure
- Package axis_video_pkg holds:
  - COMP_W and the derived DATA_W.
  - typedef pix_t, a struct of three COMP_W components.
  - typedef beat_t, holding pix_t, user and last.
  - the FSM state enum.
  - function pix_avg.
- One sub-module, axis_video_obuf: a registered output stage holding the AXI4-Stream stable while m_tready is low. The FSM drives it with a load/accept pair.

## Test plan
- MODE=0, line {10,20,30,40} (all components equal), tlast on 40 -> output 10,10,20,20,30,30,40,40 with tlast only on the 8th beat.
- MODE=1, same line -> output 10,15,20,25,30,35,40,40. Also send 11,20 -> 11,16 (rounds up).
- A 240x640 frame from the vsampler with random m_tready (50%) -> 480 beats per line, 640 lines, tuser on exactly one beat, and data identical to the no-backpressure run.
- A one-pixel line, and a frame with tuser mid-line in MODE=1 -> 2 beats for the one-pixel line; sof_early=1 for exactly one cycle; the new frame starts with tuser and no data is lost.
- Deassert aresetn while in EMIT_B -> outputs are 0 within the same cycle. A fresh frame after release upsamples correctly with no stale pixel.
